// File: rtl/dmem_access_ctrl_if.sv
// Load/store request, response and data-memory bus of dmem_access_ctrl.
// The slave modport is the controller's view; master is the CPU + memory side.
interface dmem_access_ctrl_if #(
  parameter int ADDR_W = 14
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic              resp_err;
  logic [31:0]       resp_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_re;
  logic              mem_we;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_err, resp_rdata, mem_addr, mem_re, mem_we, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_err, resp_rdata, mem_addr, mem_re, mem_we, mem_wdata
  );
endinterface

// File: rtl/dmem_access_ctrl.sv
// Load/store access controller for a single-port, word-wide data memory.
// Checks alignment, absorbs the one-cycle read latency, extends load data and
// performs read-modify-write for byte/halfword stores.
module dmem_access_ctrl #(
  parameter int ADDR_W = 14
) (
  input logic                clk,
  input logic                rst_n,
  dmem_access_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_RWAIT = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic              r_we;
  logic [1:0]        r_size;
  logic              r_unsigned;
  logic [1:0]        r_lane;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wbuf;
  logic              r_err;
  logic [31:0]       r_rdata;
  logic              w_err;
  logic              w_accept;

  // Address bits above the memory's reach simply wrap.
  logic w_unused_addr;
  assign w_unused_addr = ^bus.req_addr[31:ADDR_W+2];

  // Size 11 is never legal; halves need an even address, words a 4-aligned one.
  function automatic logic f_illegal(input logic [1:0] size, input logic [1:0] lo);
    logic bad;
    case (size)
      2'b00:   bad = 1'b0;
      2'b01:   bad = lo[0];
      2'b10:   bad = (lo != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  // Pick the addressed lane out of a memory word and sign/zero extend it.
  function automatic logic [31:0] f_load_extend(input logic [31:0] word, input logic [1:0] size,
                                                input logic [1:0] lane, input logic uns);
    logic [31:0] sh;
    logic [31:0] res;
    sh = word >> {lane, 3'b000};
    case (size)
      2'b00:   res = uns ? {24'h000000, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
      2'b01:   res = uns ? {16'h0000, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default: res = sh;
    endcase
    return res;
  endfunction

  // Replace the addressed byte/half of the old word with the low store bits.
  function automatic logic [31:0] f_merge(input logic [31:0] old_word, input logic [31:0] wdata,
                                          input logic [1:0] size, input logic [1:0] lane);
    logic [31:0] mask;
    case (size)
      2'b00:   mask = 32'h0000_00FF << {lane, 3'b000};
      2'b01:   mask = 32'h0000_FFFF << {lane, 3'b000};
      default: mask = 32'hFFFF_FFFF;
    endcase
    return (old_word & ~mask) | ((wdata << {lane, 3'b000}) & mask);
  endfunction

  assign w_err    = f_illegal(bus.req_size, bus.req_addr[1:0]);
  assign w_accept = bus.req_valid && (r_state == S_IDLE);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (!bus.req_valid) begin
          w_next = S_IDLE;
        end else if (w_err) begin
          w_next = S_DONE;
        end else if (bus.req_we && (bus.req_size == 2'b10)) begin
          w_next = S_WRITE;
        end else begin
          w_next = S_READ;
        end
      end
      S_READ:  w_next = S_RWAIT;
      S_RWAIT: begin
        if (r_we) begin
          w_next = S_WRITE;
        end else begin
          w_next = S_DONE;
        end
      end
      S_WRITE: w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Request latch, load result and write buffer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_we       <= 1'b0;
      r_size     <= 2'b00;
      r_unsigned <= 1'b0;
      r_lane     <= 2'b00;
      r_addr     <= '0;
      r_wbuf     <= 32'h0000_0000;
      r_err      <= 1'b0;
      r_rdata    <= 32'h0000_0000;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_we       <= bus.req_we;
            r_size     <= bus.req_size;
            r_unsigned <= bus.req_unsigned;
            r_lane     <= bus.req_addr[1:0];
            r_addr     <= bus.req_addr[ADDR_W+1:2];
            r_wbuf     <= bus.req_wdata;
            r_err      <= w_err;
          end
        end
        S_RWAIT: begin
          if (r_we) begin
            r_wbuf <= f_merge(bus.mem_rdata, r_wbuf, r_size, r_lane);
          end else begin
            r_rdata <= f_load_extend(bus.mem_rdata, r_size, r_lane, r_unsigned);
          end
        end
        default: begin
          r_wbuf <= r_wbuf;
        end
      endcase
    end
  end

  // Output decode: strobes and handshakes depend on state only.
  always_comb begin
    bus.req_ready  = 1'b0;
    bus.mem_re     = 1'b0;
    bus.mem_we     = 1'b0;
    bus.resp_valid = 1'b0;
    bus.resp_err   = 1'b0;
    bus.mem_addr   = r_addr;
    bus.mem_wdata  = r_wbuf;
    bus.resp_rdata = r_rdata;
    case (r_state)
      S_IDLE:  bus.req_ready = 1'b1;
      S_READ:  bus.mem_re    = 1'b1;
      S_WRITE: bus.mem_we    = 1'b1;
      S_DONE: begin
        bus.resp_valid = 1'b1;
        bus.resp_err   = r_err;
      end
      default: bus.req_ready = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Self-checking bench for dmem_access_ctrl: directed vector table, reset corner
// sequences, and random traffic against a byte-level reference model.
module tb_dmem_access_ctrl;
  localparam int ADDR_W = 14;
  localparam int DEPTH  = 1 << ADDR_W;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_rdata;
    int          exp_lat;
    logic        chk_w;
    logic [13:0] exp_waddr;
    logic [31:0] exp_wdata;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;
  logic [31:0] model_rdata = 32'h0;
  logic [31:0] tb_mem  [DEPTH];
  logic [31:0] ref_mem [DEPTH];
  vec_t vecs[$];

  dmem_access_ctrl_if #(.ADDR_W(ADDR_W)) bus();
  dmem_access_ctrl #(.ADDR_W(ADDR_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  // Single-port memory with one-cycle read latency.
  always @(posedge clk) begin
    if (bus.mem_we) tb_mem[bus.mem_addr] <= bus.mem_wdata;
    if (bus.mem_re) bus.mem_rdata <= tb_mem[bus.mem_addr];
  end

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, got, exp);
    end
  endtask

  function automatic vec_t mk(input logic we, input logic [1:0] size, input logic uns,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic exp_err, input logic [31:0] exp_rdata, input int exp_lat,
                              input logic chk_w, input logic [13:0] exp_waddr,
                              input logic [31:0] exp_wdata);
    vec_t v;
    v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
    v.exp_err = exp_err; v.exp_rdata = exp_rdata; v.exp_lat = exp_lat;
    v.chk_w = chk_w; v.exp_waddr = exp_waddr; v.exp_wdata = exp_wdata;
    return v;
  endfunction

  // Reference: byte-lane view of memory, updated and read one byte at a time.
  task automatic model(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata, output vec_t v);
    int off, idx, nb;
    logic [31:0] val;
    off = int'(addr % 32'd4);
    idx = int'((addr / 32'd4) % 32'(DEPTH));
    nb  = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    v = mk(we, size, uns, addr, wdata, 1'b0, model_rdata, 0, 1'b0, 14'd0, 32'h0);
    if (size == 2'd3 || (off % nb) != 0) begin
      v.exp_err = 1'b1;
      v.exp_lat = 1;
    end else if (we) begin
      for (int i = 0; i < nb; i++) ref_mem[idx][8*(off+i) +: 8] = wdata[8*i +: 8];
      v.exp_lat   = (nb == 4) ? 2 : 4;
      v.chk_w     = 1'b1;
      v.exp_waddr = idx[13:0];
      v.exp_wdata = ref_mem[idx];
    end else begin
      val = 32'h0;
      for (int i = 0; i < nb; i++) val[8*i +: 8] = ref_mem[idx][8*(off+i) +: 8];
      if (!uns && nb < 4 && val[8*nb-1]) val = val | (32'hFFFF_FFFF << (8*nb));
      model_rdata = val;
      v.exp_rdata = val;
      v.exp_lat   = 3;
    end
  endtask

  // Drive one request and observe it until its response (bounded).
  task automatic do_req(input vec_t v, output logic err, output logic [31:0] rdata, output int lat,
                        output logic seen_re, output logic seen_we, output logic [13:0] waddr,
                        output logic [31:0] wd, output logic post_ok);
    int waited;
    err = 1'b0; rdata = 32'h0; lat = 0; seen_re = 1'b0; seen_we = 1'b0;
    waddr = 14'd0; wd = 32'h0; post_ok = 1'b0; waited = 0;
    @(negedge clk);
    while (!bus.req_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check("ready_wait", {31'h0, bus.req_ready}, 32'h1);
    bus.req_valid = 1'b1; bus.req_we = v.we; bus.req_size = v.size;
    bus.req_unsigned = v.uns; bus.req_addr = v.addr; bus.req_wdata = v.wdata;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      lat = c;
      if (bus.mem_re) seen_re = 1'b1;
      if (bus.mem_we) begin
        seen_we = 1'b1; waddr = bus.mem_addr; wd = bus.mem_wdata;
      end
      if (bus.resp_valid) begin
        err = bus.resp_err; rdata = bus.resp_rdata;
        break;
      end
    end
    @(negedge clk);
    post_ok = bus.req_ready && !bus.resp_valid;
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    logic err, sre, swe, pok;
    logic [31:0] rd, wd;
    logic [13:0] wa;
    int lat;
    do_req(v, err, rd, lat, sre, swe, wa, wd, pok);
    check({tag, "_lat"}, 32'(lat), 32'(v.exp_lat));
    check({tag, "_err"}, {31'h0, err}, {31'h0, v.exp_err});
    check({tag, "_rdata"}, rd, v.exp_rdata);
    check({tag, "_pulse"}, {31'h0, pok}, 32'h1);
    check({tag, "_re_we_excl"}, {31'h0, v.exp_err & (sre | swe)}, 32'h0);
    if (v.chk_w) begin
      check({tag, "_waddr"}, {18'h0, wa}, {18'h0, v.exp_waddr});
      check({tag, "_wdata"}, wd, v.exp_wdata);
      check({tag, "_mem"}, tb_mem[v.exp_waddr], v.exp_wdata);
    end
  endtask

  initial begin
    vec_t v, d;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'b00;
    bus.req_unsigned = 1'b0; bus.req_addr = 32'h0; bus.req_wdata = 32'h0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_resp_valid", {31'h0, bus.resp_valid}, 32'h0);
    check("rst_resp_err", {31'h0, bus.resp_err}, 32'h0);
    check("rst_resp_rdata", bus.resp_rdata, 32'h0);
    check("rst_mem_re_we", {30'h0, bus.mem_re, bus.mem_we}, 32'h0);
    check("rst_mem_addr", {18'h0, bus.mem_addr}, 32'h0);
    check("rst_mem_wdata", bus.mem_wdata, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", {31'h0, bus.req_ready}, 32'h1);

    // Preload the working region (words 0..15) with random data
    for (int i = 0; i < 16; i++) begin
      model(1'b1, 2'b10, 1'b0, 32'(i * 4), $urandom(), v);
      run_vec("preload", v);
    end

    // Directed vectors with hand-derived expectations
    vecs.push_back(mk(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0, 2, 1'b1, 14'd4, 32'hDEADBEEF));
    vecs.push_back(mk(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF, 3, 1'b0, 14'd0, 32'h0));
    vecs.push_back(mk(1'b1, 2'b10, 1'b0, 32'h10, 32'h11223344, 1'b0, 32'hDEADBEEF, 2, 1'b1, 14'd4, 32'h11223344));
    vecs.push_back(mk(1'b1, 2'b00, 1'b0, 32'h12, 32'h000000AA, 1'b0, 32'hDEADBEEF, 4, 1'b1, 14'd4, 32'h11AA3344));
    vecs.push_back(mk(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, 32'h11AA3344, 3, 1'b0, 14'd0, 32'h0));
    vecs.push_back(mk(1'b0, 2'b00, 1'b0, 32'h12, 32'h0, 1'b0, 32'hFFFFFFAA, 3, 1'b0, 14'd0, 32'h0));
    vecs.push_back(mk(1'b0, 2'b00, 1'b1, 32'h12, 32'h0, 1'b0, 32'h000000AA, 3, 1'b0, 14'd0, 32'h0));
    vecs.push_back(mk(1'b1, 2'b10, 1'b0, 32'h10, 32'h80013344, 1'b0, 32'h000000AA, 2, 1'b1, 14'd4, 32'h80013344));
    vecs.push_back(mk(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 1'b0, 32'hFFFF8001, 3, 1'b0, 14'd0, 32'h0));
    vecs.push_back(mk(1'b0, 2'b01, 1'b0, 32'h13, 32'h0, 1'b1, 32'hFFFF8001, 1, 1'b0, 14'd0, 32'h0));
    vecs.push_back(mk(1'b1, 2'b10, 1'b0, 32'h06, 32'h12345678, 1'b1, 32'hFFFF8001, 1, 1'b0, 14'd0, 32'h0));
    vecs.push_back(mk(1'b0, 2'b11, 1'b0, 32'h00, 32'h0, 1'b1, 32'hFFFF8001, 1, 1'b0, 14'd0, 32'h0));
    vecs.push_back(mk(1'b1, 2'b10, 1'b0, 32'h0001_0004, 32'hCAFEF00D, 1'b0, 32'hFFFF8001, 2, 1'b1, 14'd1, 32'hCAFEF00D));
    vecs.push_back(mk(1'b0, 2'b10, 1'b0, 32'h04, 32'h0, 1'b0, 32'hCAFEF00D, 3, 1'b0, 14'd0, 32'h0));
    for (int i = 0; i < vecs.size(); i++) begin
      model(vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata, d);
      run_vec($sformatf("vec%0d", i), vecs[i]);
    end

    // Reset during RWAIT of a byte store: no write, no response
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'b00;
    bus.req_unsigned = 1'b0; bus.req_addr = 32'h21; bus.req_wdata = 32'h55;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    check("rwait_rst_read", {31'h0, bus.mem_re}, 32'h1);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rwait_rst_no_we", {31'h0, bus.mem_we}, 32'h0);
    check("rwait_rst_no_resp", {31'h0, bus.resp_valid}, 32'h0);
    check("rwait_rst_mem", tb_mem[8], ref_mem[8]);
    check("rwait_rst_rdata", bus.resp_rdata, 32'h0);
    rst_n = 1'b1;
    model_rdata = 32'h0;
    @(negedge clk);
    check("rwait_rst_ready", {31'h0, bus.req_ready}, 32'h1);

    // Reset during WRITE of a word store: write lands, no response
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'b10;
    bus.req_addr = 32'h24; bus.req_wdata = 32'h0BADF00D;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    check("write_rst_we", {31'h0, bus.mem_we}, 32'h1);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("write_rst_no_resp", {31'h0, bus.resp_valid}, 32'h0);
    check("write_rst_mem", tb_mem[9], 32'h0BADF00D);
    rst_n = 1'b1;
    model(1'b1, 2'b10, 1'b0, 32'h24, 32'h0BADF00D, d);
    model_rdata = 32'h0;
    model(1'b0, 2'b10, 1'b0, 32'h24, 32'h0, v);
    run_vec("write_rst_load", v);

    // Random traffic against the reference model
    for (int i = 0; i < 300; i++) begin
      logic [31:0] a;
      a = ($urandom() & 32'hFFFF_0000) | 32'($urandom_range(0, 63));
      model(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            a, $urandom(), v);
      run_vec("rand", v);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_access_ctrl.md
# dmem_access_ctrl

Load/store access controller between the CPU datapath and the single-port word-wide data memory. Accepts byte/halfword/word load and store requests on byte addresses, checks alignment, drives the memory's word address/write-enable/write-data, absorbs the memory's one-cycle read latency, and returns sign- or zero-extended load data. Sub-word stores use an internal read-modify-write sequence because the memory has a single whole-word write enable.

## Interface
- ADDR_W, 14, word-address width of the data memory
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  synchronous reset, active-low
- req_valid  in  1  request present
- req_ready  out  1  controller can accept; high only in IDLE
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal
- req_unsigned  in  1  loads: 1 = zero-extend, 0 = sign-extend
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- resp_valid  out  1  one-cycle completion pulse
- resp_err  out  1  valid with resp_valid; misaligned or illegal size
- resp_rdata  out  32  load result; held until next response
- mem_addr  out  ADDR_W  word address = latched req_addr[ADDR_W+1:2]
- mem_re  out  1  read strobe
- mem_we  out  1  whole-word write enable
- mem_wdata  out  32  word to write
- mem_rdata  in  32  memory data, valid the cycle after mem_addr is sampled

## Operation
- Request fields latched on req_valid && req_ready; address bits above ADDR_W+1 ignored (wrap).
- Alignment: half needs addr[0]=0; word needs addr[1:0]=00; size 11 always illegal. Error requests touch no memory.
- Lanes little-endian: byte k = bits [8k+7:8k], k = addr[1:0]; half h = bits [16h+15:16h], h = addr[1].
- States: IDLE, READ, RWAIT, WRITE, DONE.
- IDLE: req_ready=1. Accept -> DONE (error), WRITE (word store), READ (load or sub-word store).
- READ: mem_re=1, mem_addr driven -> RWAIT.
- RWAIT: mem_rdata valid. Load: extract lane, extend per req_unsigned/size, register into resp_rdata -> DONE. Sub-word store: replace addressed lane(s) in mem_rdata with req_wdata low bits, register into write buffer -> WRITE.
- WRITE: mem_we=1, mem_addr, mem_wdata = buffer (word store: req_wdata verbatim) -> DONE.
- DONE: resp_valid=1, resp_err as latched; stores and errors leave resp_rdata unchanged -> IDLE.
- mem_re/mem_we are decoded from state only; never both high; both 0 in IDLE, RWAIT, DONE.

## Timing
- Reset (rst_n=0 at edge): state IDLE; resp_valid=0, resp_err=0, resp_rdata=0, mem_re=0, mem_we=0, mem_addr=0, mem_wdata=0, req_ready=1 next cycle.
- Accept at cycle T. Response (resp_valid) at: error T+1; word store T+2; load T+3; sub-word store T+4.
- Back-to-back: req_ready rises in the cycle after DONE; next accept earliest then.
- No response backpressure: resp_valid is a single-cycle pulse.
- Reset mid-operation: if rst_n=0 during WRITE the memory still samples mem_we=1 at that edge (write lands); no response issued. Reset in any other state aborts with no memory side effect.
- req_valid while req_ready=0 is ignored; requester holds it.

## Test plan
- Word store 0xDEADBEEF @0x10, then word load @0x10 -> mem_we at T+1 with mem_addr=4; load resp_rdata=0xDEADBEEF at T+3, resp_err=0.
- Byte store 0xAA @0x12 over 0x11223344 -> READ/RWAIT/WRITE, mem_wdata=0x11AA3344, resp at T+4; subsequent word load returns 0x11AA3344.
- Byte load @0x12 of 0x11AA3344: signed -> 0xFFFFFFAA; unsigned -> 0x000000AA. Half load @0x12 signed of 0x80013344 -> 0xFFFF8001.
- Misaligned half load @0x13, word store @0x06, size 11 -> resp_err=1 at T+1, mem_re/mem_we never asserted, resp_rdata unchanged.
- Address 0x0001_0004 with ADDR_W=14 -> mem_addr=1 (upper bits wrap).
- rst_n=0 asserted during RWAIT of a sub-word store -> no mem_we, no resp_valid, memory word unchanged, req_ready=1 after reset releases.
